uart_prog_loader: RTL and testbench

- Boot-time program loader between the SoC UART RX pin and instruction memory.
- Deserialises 8N1 UART bytes and assembles them little-endian into 32-bit words.
- Writes each word to consecutive instruction-memory word addresses over a req/gnt port.
- Holds the core in reset until a terminator word arrives, then releases it.

---
 rtl/uart_prog_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Boot-time program loader: receives 8N1 UART bytes, packs them little-endian into 32-bit
// words, writes each word to consecutive instruction-memory addresses, and releases the
// core reset once the terminator word arrives.
module uart_prog_loader #(
  parameter int unsigned CLK_FREQ     = 10000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD + 1,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned BASE_ADDR    = 0,
  parameter logic [31:0] EOP_WORD     = 32'h00000FFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  core_rst_no,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic                  rx_meta_q, rx_sync_q;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  stop_bad_q, stop_bad_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  done_q, done_d;
  logic                  eop_pend_q, eop_pend_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  byte_valid, frame_err_set;
  logic [31:0]           full_word;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM next state: mid-bit sampling, byte_valid pulses on a good stop bit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    stop_bad_d    = stop_bad_q;
    byte_valid    = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      StIdle: begin
        // Once the terminator is seen (or queued behind a write) the line is ignored.
        if (!rx_sync_q && !done_q && !eop_pend_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_sync_q;
          bit_d          = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (stop_bad_q) begin
          // Bad stop bit: linger until the line returns to idle.
          if (rx_sync_q) begin
            state_d    = StIdle;
            stop_bad_d = 1'b0;
          end
        end else if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_set = 1'b1;
            stop_bad_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en_i) begin
      state_d       = StIdle;
      stop_bad_d    = 1'b0;
      byte_valid    = 1'b0;
      frame_err_set = 1'b0;
    end
  end

  // Word assembly, write buffer, grant handling and sticky status flags.
  always_comb begin
    idx_d       = idx_q;
    word_d      = word_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    done_d      = done_q;
    eop_pend_d  = eop_pend_q;
    frame_err_d = frame_err_q | frame_err_set;
    overrun_d   = overrun_q;
    full_word   = {shift_q, word_q};
    if (req_q && mem_gnt_i) begin
      req_d   = 1'b0;
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    // Terminator that arrived behind a pending write is released once that write is granted.
    if (eop_pend_q && !req_q) begin
      done_d     = 1'b1;
      eop_pend_d = 1'b0;
    end
    if (byte_valid) begin
      case (idx_q)
        2'd0:    word_d[7:0]   = shift_q;
        2'd1:    word_d[15:8]  = shift_q;
        2'd2:    word_d[23:16] = shift_q;
        default: ;
      endcase
      idx_d = idx_q + 1'b1;
      if (idx_q == 2'd3) begin
        if (full_word == EOP_WORD) begin
          if (req_q) eop_pend_d = 1'b1;
          else       done_d     = 1'b1;
        end else if (req_q) begin
          overrun_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          wdata_d = full_word;
        end
      end
    end
    if (!en_i) idx_d = '0;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      stop_bad_q  <= 1'b0;
      idx_q       <= '0;
      word_q      <= '0;
      req_q       <= 1'b0;
      addr_q      <= BaseAddr;
      wdata_q     <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      eop_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      stop_bad_q  <= stop_bad_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      done_q      <= done_d;
      eop_pend_q  <= eop_pend_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_we_o     = req_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_be_o     = {4{req_q}};
  assign busy_o       = (state_q != StIdle) | req_q;
  assign done_o       = done_q;
  assign core_rst_no  = done_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed UART frames, a byte/word-level model of the
// expected memory writes, and a per-cycle checker on the write port.
module tb_uart_prog_loader;

  localparam int unsigned CPB = 87;
  localparam int unsigned AW  = 12;
  localparam logic [31:0] EOP = 32'h00000FFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          rx = 1'b1;
  logic          gnt = 1'b0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          busy_o, done_o, core_rst_no, frame_err_o, overrun_o;
  logic [AW:0]   word_count_o;

  uart_prog_loader #(
    .CLK_FREQ  (10000000),
    .BAUD      (115200),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (0),
    .EOP_WORD  (EOP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .rx_i        (rx),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_gnt_i   (gnt),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .core_rst_no (core_rst_no),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .word_count_o(word_count_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  byte_buf[$];
  int          exp_count = 0;
  logic        exp_done = 1'b0;
  logic        exp_ferr = 1'b0;
  int          gnt_delay = 0;
  int          req_seen = 0;
  int          req_len = 0;
  logic [31:0] last_wdata = '0;
  logic        no_busy_win = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: what a received byte means for the memory image and the flags.
  task automatic model_byte(input logic [7:0] b, input logic ok);
    logic [31:0] w;
    if (!en || exp_done) return;
    if (!ok) begin
      exp_ferr = 1'b1;
      return;
    end
    byte_buf.push_back(b);
    if (byte_buf.size() == 4) begin
      w = {byte_buf[3], byte_buf[2], byte_buf[1], byte_buf[0]};
      byte_buf.delete();
      if (w == EOP) exp_done = 1'b1;
      else          exp_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    model_byte(b, stop_ok);
    rx = stop_ok;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(20);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    byte_buf.delete();
    exp_count = 0;
    exp_done  = 1'b0;
    exp_ferr  = 1'b0;
    req_len   = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    model_reset();
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},       mem_req_o,    1'b0);
    chk({tag, "_we"},        mem_we_o,     1'b0);
    chk({tag, "_addr"},      mem_addr_o,   '0);
    chk({tag, "_wdata"},     mem_wdata_o,  '0);
    chk({tag, "_be"},        mem_be_o,     4'h0);
    chk({tag, "_busy"},      busy_o,       1'b0);
    chk({tag, "_done"},      done_o,       1'b0);
    chk({tag, "_core_rst"},  core_rst_no,  1'b0);
    chk({tag, "_frame_err"}, frame_err_o,  1'b0);
    chk({tag, "_overrun"},   overrun_o,    1'b0);
    chk({tag, "_count"},     word_count_o, '0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_done"},        done_o,        exp_done);
    chk({tag, "_frame_err"},   frame_err_o,   exp_ferr);
    chk({tag, "_overrun"},     overrun_o,     1'b0);
    chk({tag, "_busy"},        busy_o,        1'b0);
    chk({tag, "_outstanding"}, exp_q.size(),  0);
  endtask

  // Grant driver: tied high, or raised gnt_delay cycles after req rises.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gnt_delay == 0) begin
        gnt = 1'b1;
      end else if (mem_req_o) begin
        req_seen++;
        gnt = (req_seen > gnt_delay);
      end else begin
        req_seen = 0;
        gnt      = 1'b0;
      end
    end
  end

  // Per-cycle write-port checker against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mem_be", mem_be_o, mem_req_o ? 4'hF : 4'h0);
        chk("mem_we", mem_we_o, mem_req_o);
        chk("core_rst_no", core_rst_no, done_o);
        chk("word_count", word_count_o, exp_count);
        chk("mem_addr", mem_addr_o, exp_count[AW-1:0]);
        if (mem_req_o) begin
          if (exp_q.size() == 0) begin
            chk("write_expected", exp_q.size(), 1);
          end else begin
            chk("mem_wdata", mem_wdata_o, exp_q[0]);
            req_len++;
            if (gnt) begin
              chk("req_cycles", req_len, (gnt_delay == 0) ? 1 : gnt_delay + 1);
              last_wdata = mem_wdata_o;
              void'(exp_q.pop_front());
              exp_count++;
              req_len = 0;
            end
          end
        end
        if (no_busy_win) chk("busy_after_done", busy_o, 1'b0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wait_cycles(3);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    wait_cycles(5);

    // Baseline write with grant tied high.
    send_word(32'h00200113);
    wait_cycles(30);
    chk_quiet("base");
    chk("base_count", word_count_o, 1);
    chk("base_addr", mem_addr_o, 12'd1);
    chk("base_wdata", last_wdata, 32'h00200113);

    // Grant five cycles after request.
    gnt_delay = 5;
    send_word(32'h00200113);
    wait_cycles(30);
    chk_quiet("dly");
    chk("dly_count", word_count_o, 2);
    chk("dly_addr", mem_addr_o, 12'd2);
    gnt_delay = 0;

    // Short low glitch must not start a byte.
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(200);
    chk_quiet("glitch");
    chk("glitch_count", word_count_o, 2);

    // Disable after two bytes discards the partial word.
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    en = 1'b0;
    byte_buf.delete();
    wait_cycles(10);
    en = 1'b1;
    wait_cycles(10);
    send_word(32'hDEADBEEF);
    wait_cycles(30);
    chk_quiet("dis");
    chk("dis_count", word_count_o, 3);
    chk("dis_wdata", last_wdata, 32'hDEADBEEF);

    // Asynchronous reset in the middle of a data bit.
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(100);
    chk("mid_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("async");
    model_reset();
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(5);
    send_word(32'h12345678);
    wait_cycles(30);
    chk_quiet("rst");
    chk("rst_count", word_count_o, 1);
    chk("rst_wdata", last_wdata, 32'h12345678);

    // Bad stop bit, then a clean word.
    apply_reset();
    send_byte(8'h55, 1'b0);
    send_word(32'hCAFEF00D);
    wait_cycles(30);
    chk_quiet("ferr");
    chk("ferr_flag", frame_err_o, 1'b1);
    chk("ferr_count", word_count_o, 1);
    chk("ferr_wdata", last_wdata, 32'hCAFEF00D);

    // Two data words, the terminator, then traffic that must be ignored.
    apply_reset();
    send_word(32'h00000093);
    send_word(32'h00100113);
    send_word(EOP);
    wait_cycles(20);
    chk_quiet("eop");
    chk("eop_done", done_o, 1'b1);
    chk("eop_core_rst", core_rst_no, 1'b1);
    chk("eop_count", word_count_o, 2);
    chk("eop_addr", mem_addr_o, 12'd2);
    no_busy_win = 1'b1;
    send_word(32'h11223344);
    no_busy_win = 1'b0;
    chk("post_count", word_count_o, 2);
    chk_quiet("post");
    wait_cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
